// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch responder
// and its word array.
package imem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } imem_state_e;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
   localparam int          WAIT_CNT_W = 4;

   function automatic int imem_index_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/imem_word_array.sv
// DEPTH x 32 instruction storage: one write port for program load, one
// synchronous read port whose output register is the fetched word.
module imem_word_array
   import imem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = imem_index_width(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [31:0]   i_wr_data,
   input  logic          i_rd_en,
   input  logic [AW-1:0] i_rd_addr,
   output logic [31:0]   o_rd_data
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdData;

   // Storage is never reset so it maps onto block RAM.
   always_ff @(posedge clock) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Same-edge write and read of one word returns the old contents.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_rdData <= NOP_INSTR;
      end else if (i_rd_en) begin
         r_rdData <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rdData;

endmodule

// File: rtl/imem_fetch_responder.sv
// Fetch-side instruction memory responder: fixed wait-state fetch FSM with
// flush and program load. Define IMEM_FETCH_ERR_EN to add the rsp_err port.
module imem_fetch_responder
   import imem_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   output logic        req_ready,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] instr,
`ifdef IMEM_FETCH_ERR_EN
   output logic        rsp_err,
`endif
   input  logic        flush,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data
);

   localparam int                    AW           = imem_index_width(DEPTH);
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD    =
      WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam imem_state_e           LAUNCH_STATE = (WAIT_CYCLES == 0) ? RESP : WAIT;

   imem_state_e           r_state;
   imem_state_e           w_nextState;
   logic [WAIT_CNT_W-1:0] r_waitCnt;
   logic [WAIT_CNT_W-1:0] w_nextWaitCnt;
   logic [AW-1:0]         r_wordIdx;
   logic [AW-1:0]         w_reqIdx;
   logic [AW-1:0]         w_rdIdx;
   logic                  w_accept;
   logic                  w_waitDone;
   logic                  w_rdEn;
   logic [31:0]           w_rdData;

   assign w_reqIdx   = req_addr[AW+1:2];
   assign req_ready  = (r_state == IDLE) | ((r_state == RESP) & rsp_ready & ~flush);
   assign w_accept   = req_valid & req_ready;
   assign w_waitDone = (r_state == WAIT) & ~flush & (r_waitCnt == '0);
   assign rsp_valid  = (r_state == RESP);

   // The array is read on the edge that enters RESP: straight from the request
   // when there are no wait states, otherwise from the captured index.
   assign w_rdEn  = (w_accept & (LAUNCH_STATE == RESP)) | w_waitDone;
   assign w_rdIdx = w_accept ? w_reqIdx : r_wordIdx;

   always_comb begin
      w_nextState   = r_state;
      w_nextWaitCnt = r_waitCnt;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nextState   = LAUNCH_STATE;
               w_nextWaitCnt = WAIT_LOAD;
            end
         end
         WAIT: begin
            if (flush) begin
               w_nextState = IDLE;
            end else if (r_waitCnt == '0) begin
               w_nextState = RESP;
            end else begin
               w_nextWaitCnt = r_waitCnt - 1'b1;
            end
         end
         RESP: begin
            if (flush) begin
               w_nextState = IDLE;
            end else if (rsp_ready) begin
               if (w_accept) begin
                  w_nextState   = LAUNCH_STATE;
                  w_nextWaitCnt = WAIT_LOAD;
               end else begin
                  w_nextState = IDLE;
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_waitCnt <= '0;
         r_wordIdx <= '0;
      end else begin
         r_state   <= w_nextState;
         r_waitCnt <= w_nextWaitCnt;
         if (w_accept) begin
            r_wordIdx <= w_reqIdx;
         end
      end
   end

   imem_word_array #(
      .DEPTH (DEPTH)
   ) u_word_array (
      .clock     (clock),
      .reset     (reset),
      .i_wr_en   (ld_en),
      .i_wr_addr (ld_addr[AW-1:0]),
      .i_wr_data (ld_data),
      .i_rd_en   (w_rdEn),
      .i_rd_addr (w_rdIdx),
      .o_rd_data (w_rdData)
   );

`ifdef IMEM_FETCH_ERR_EN
   logic w_reqErr;
   logic r_pendErr;
   logic r_rspErr;
   logic w_unused;

   // DEPTH is a power of two, so any set bit above the index is out of range.
   assign w_reqErr = (req_addr[1:0] != 2'b00) | (req_addr[31:AW+2] != '0);

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_pendErr <= 1'b0;
         r_rspErr  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_pendErr <= w_reqErr;
         end
         if (w_rdEn) begin
            r_rspErr <= w_accept ? w_reqErr : r_pendErr;
         end
      end
   end

   assign rsp_err  = r_rspErr & rsp_valid;
   assign instr    = r_rspErr ? NOP_INSTR : w_rdData;
   assign w_unused = ^ld_addr[31:AW];
`else
   logic w_unused;

   assign instr    = w_rdData;
   assign w_unused = ^{req_addr[31:AW+2], req_addr[1:0], ld_addr[31:AW]};
`endif

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder: one DUT with one wait state, one
// with none, each checked against a cycle-level transaction model.
module tb_imem_fetch_responder;

   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int WC0   = 1;
   localparam int WC1   = 0;
`ifdef IMEM_FETCH_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] instr;
      logic        err;
      int          vis;
   } exp_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   // Cycle index: a request accepted in cycle k is answered in cycle k+WC+1.
   int cyc = 0;
   always @(posedge clock) cyc++;

   logic [1:0]  resetN;
   logic [1:0]  reqValid;
   logic [1:0]  reqReady;
   logic [1:0]  rspValid;
   logic [1:0]  rspReady;
   logic [1:0]  flush;
   logic [1:0]  ldEn;
   logic [31:0] reqAddr [2];
   logic [31:0] instr   [2];
   logic [31:0] ldAddr  [2];
   logic [31:0] ldData  [2];
`ifdef IMEM_FETCH_ERR_EN
   logic [1:0]  rspErr;
`endif

   imem_fetch_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC0)) u_dut0 (
      .clock     (clock),
      .reset     (resetN[0]),
      .req_valid (reqValid[0]),
      .req_addr  (reqAddr[0]),
      .req_ready (reqReady[0]),
      .rsp_valid (rspValid[0]),
      .rsp_ready (rspReady[0]),
      .instr     (instr[0]),
`ifdef IMEM_FETCH_ERR_EN
      .rsp_err   (rspErr[0]),
`endif
      .flush     (flush[0]),
      .ld_en     (ldEn[0]),
      .ld_addr   (ldAddr[0]),
      .ld_data   (ldData[0])
   );

   imem_fetch_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC1)) u_dut1 (
      .clock     (clock),
      .reset     (resetN[1]),
      .req_valid (reqValid[1]),
      .req_addr  (reqAddr[1]),
      .req_ready (reqReady[1]),
      .rsp_valid (rspValid[1]),
      .rsp_ready (rspReady[1]),
      .instr     (instr[1]),
`ifdef IMEM_FETCH_ERR_EN
      .rsp_err   (rspErr[1]),
`endif
      .flush     (flush[1]),
      .ld_en     (ldEn[1]),
      .ld_addr   (ldAddr[1]),
      .ld_data   (ldData[1])
   );

   // Reference model state: memory image, one outstanding fetch per DUT.
   logic [31:0] memModel [2][DEPTH];
   bit          pend [2];
   int          pendVis [2];
   bit          expReady [2];
   bit          lastAccepted [2];
   exp_t        q0 [$];
   exp_t        q1 [$];

   bit          prevValid [2];
   bit          prevRetired [2];
   logic [31:0] prevInstr [2];

   int checks = 0;
   int errors = 0;

   function automatic int wcOf(input int d);
      return (d == 0) ? WC0 : WC1;
   endfunction

   function automatic int qSize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t qFront(input int d);
      exp_t e;
      if (d == 0) e = q0[0];
      else        e = q1[0];
      return e;
   endfunction

   function automatic void qPush(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endfunction

   function automatic void qPopFront(input int d);
      if (d == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
   endfunction

   function automatic void qPopBack(input int d);
      if (d == 0) void'(q0.pop_back());
      else        void'(q1.pop_back());
   endfunction

   function automatic void qClear(input int d);
      if (d == 0) q0.delete();
      else        q1.delete();
   endfunction

   function automatic logic [31:0] randAddr();
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 7) return {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
      if (sel == 7) return $urandom();
      if (sel == 8) return 32'(DEPTH * 4) + {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
      return {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
   endfunction

   task automatic checkOutput(input string name, input int d, input logic [31:0] got,
                              input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s dut%0d cycle %0d: got %h, expected %h", name, d, cyc, got, want);
      end
   endtask

   // Drive one cycle of inputs and advance the model by the same cycle.
   task automatic applyStimulus(input int d, input bit rv, input logic [31:0] a, input bit rr,
                                input bit fl, input bit ld, input logic [31:0] la,
                                input logic [31:0] ldat);
      exp_t e;
      bit   vis;
      bit   rdy;
      int   idx;
      int   li;
      @(posedge clock);
      #1;
      reqValid[d] = rv;
      reqAddr[d]  = a;
      rspReady[d] = rr;
      flush[d]    = fl;
      ldEn[d]     = ld;
      ldAddr[d]   = la;
      ldData[d]   = ldat;

      vis         = pend[d] && (cyc >= pendVis[d]);
      rdy         = !pend[d] || (vis && rr && !fl);
      expReady[d] = rdy;
      if (pend[d] && fl) begin
         pend[d] = 1'b0;
         qPopBack(d);
      end else if (vis && rr) begin
         pend[d] = 1'b0;
      end

      li = int'(la[AW-1:0]);
      lastAccepted[d] = rv && rdy;
      if (rv && rdy) begin
         idx     = int'(a[AW+1:2]);
         e.err   = ERR_EN && ((a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH)));
         // The word is read WC cycles after acceptance, so a load issued in the
         // accepting cycle is only visible when there are wait states.
         e.instr = (ld && li == idx && wcOf(d) > 0) ? ldat : memModel[d][idx];
         if (e.err) e.instr = 32'h0;
         e.vis   = cyc + wcOf(d) + 1;
         qPush(d, e);
         pend[d]    = 1'b1;
         pendVis[d] = e.vis;
      end
      if (ld) memModel[d][li] = ldat;
   endtask

   task automatic idle(input int d, input int n, input bit rr);
      for (int i = 0; i < n; i++) applyStimulus(d, 1'b0, 32'h0, rr, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic drain(input int d);
      int n;
      n = 0;
      while (pend[d] && n < 40) begin
         applyStimulus(d, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
         n++;
      end
      checkOutput("drain_bound", d, 32'(pend[d]), 32'h0);
      idle(d, 1, 1'b1);
   endtask

   task automatic fetch(input int d, input logic [31:0] a, input bit rr);
      int n;
      n = 0;
      do begin
         applyStimulus(d, 1'b1, a, rr, 1'b0, 1'b0, 32'h0, 32'h0);
         n++;
      end while (!lastAccepted[d] && n < 40);
      checkOutput("fetch_accept_bound", d, 32'(lastAccepted[d]), 32'h1);
   endtask

   task automatic doReset(input int d);
      @(posedge clock);
      #1;
      resetN[d]   = 1'b0;
      reqValid[d] = 1'b0;
      rspReady[d] = 1'b0;
      flush[d]    = 1'b0;
      ldEn[d]     = 1'b0;
      pend[d]     = 1'b0;
      expReady[d] = 1'b1;
      qClear(d);
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      checkOutput("reset_rsp_valid", d, 32'(rspValid[d]), 32'h0);
      checkOutput("reset_instr", d, instr[d], 32'h0);
      @(posedge clock);
      #1;
      resetN[d] = 1'b1;
   endtask

   task automatic preload(input int d);
      for (int i = 0; i < DEPTH; i++)
         applyStimulus(d, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'(i) | ($urandom() << AW), $urandom());
   endtask

   task automatic randomCycles(input int d, input int n);
      bit fl;
      bit rr;
      bit ld;
      for (int i = 0; i < n; i++) begin
         fl = ($urandom_range(0, 19) == 0);
         rr = fl ? 1'b0 : ($urandom_range(0, 9) < 7);
         ld = !pend[d] && ($urandom_range(0, 9) < 2);
         applyStimulus(d, $urandom_range(0, 9) < 7, randAddr(), rr, fl, ld,
                       $urandom(), $urandom());
      end
      drain(d);
   endtask

   // Monitor: handshake and response checks against the scoreboard queue.
   task automatic monitorDut(input int d);
      exp_t e;
      bit   retire;
      retire = 1'b0;
      if (resetN[d] === 1'b1 && flush[d] === 1'b0) begin
         checkOutput("req_ready", d, 32'(reqReady[d]), 32'(expReady[d]));
         if (rspValid[d] === 1'b1) begin
            if (qSize(d) == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_rsp dut%0d cycle %0d: got rsp_valid 1, expected 0", d, cyc);
            end else begin
               e = qFront(d);
               if (!prevValid[d] || prevRetired[d]) checkOutput("latency", d, 32'(cyc), 32'(e.vis));
               else                                 checkOutput("hold_stable", d, instr[d], prevInstr[d]);
               if (rspReady[d]) begin
                  checkOutput("instr", d, instr[d], e.instr);
`ifdef IMEM_FETCH_ERR_EN
                  checkOutput("rsp_err", d, 32'(rspErr[d]), 32'(e.err));
`endif
                  qPopFront(d);
                  retire = 1'b1;
               end
            end
         end else if (qSize(d) > 0) begin
            e = qFront(d);
            if (cyc > e.vis) begin
               checkOutput("missing_rsp", d, 32'(rspValid[d]), 32'h1);
               qPopFront(d);
            end
         end
         prevValid[d]   = (rspValid[d] === 1'b1);
         prevRetired[d] = retire;
         prevInstr[d]   = instr[d];
      end else begin
         prevValid[d] = 1'b0;
      end
   endtask

   always @(negedge clock) begin
      for (int d = 0; d < 2; d++) monitorDut(d);
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      resetN   = 2'b00;
      reqValid = 2'b00;
      rspReady = 2'b00;
      flush    = 2'b00;
      ldEn     = 2'b00;
      for (int d = 0; d < 2; d++) begin
         reqAddr[d]     = 32'h0;
         ldAddr[d]      = 32'h0;
         ldData[d]      = 32'h0;
         pend[d]        = 1'b0;
         expReady[d]    = 1'b1;
         prevValid[d]   = 1'b0;
         prevRetired[d] = 1'b0;
      end

      doReset(0);
      doReset(1);

      // DUT0: one wait state.
      preload(0);
      applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'd4, 32'h2008_0005);
      applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'd2, 32'hCAFE_0002);

      // Response held with rsp_ready low for several cycles.
      fetch(0, 32'h10, 1'b0);
      idle(0, 5, 1'b0);
      @(negedge clock);
      checkOutput("t2_held_valid", 0, 32'(rspValid[0]), 32'h1);
      checkOutput("t2_held_instr", 0, instr[0], 32'h2008_0005);
      drain(0);

      // Flush while waiting, then a fresh fetch of word 2.
      fetch(0, 32'h20, 1'b0);
      applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      idle(0, 1, 1'b0);
      @(negedge clock);
      checkOutput("t4_flushed_no_rsp", 0, 32'(rspValid[0]), 32'h0);
      checkOutput("t4_idle_ready", 0, 32'(reqReady[0]), 32'h1);
      fetch(0, 32'h8, 1'b1);
      drain(0);

      // Flush while presenting a response, then flush in idle with a request.
      fetch(0, 32'h14, 1'b0);
      idle(0, 2, 1'b0);
      applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      idle(0, 2, 1'b1);
      applyStimulus(0, 1'b1, 32'h0000_000C, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      drain(0);

      fetch(0, 32'h6, 1'b1);
      fetch(0, 32'(DEPTH * 4), 1'b1);
      drain(0);

      randomCycles(0, 400);

      // Reset in the middle of a fetch drops it.
      fetch(0, 32'h4, 1'b0);
      doReset(0);
      idle(0, 4, 1'b1);

      // DUT1: no wait states.
      preload(1);
      fetch(1, 32'h0, 1'b1);
      fetch(1, 32'h4, 1'b1);
      fetch(1, 32'h8, 1'b1);
      drain(1);

      // Same-edge load and read of word 3 returns the old word; refetch gets the new one.
      applyStimulus(1, 1'b1, 32'h0000_000C, 1'b1, 1'b0, 1'b1, 32'd3, 32'h1234_5678);
      drain(1);
      fetch(1, 32'h0000_000C, 1'b1);
      drain(1);

      fetch(1, 32'h6, 1'b1);
      fetch(1, 32'(DEPTH * 4), 1'b1);
      drain(1);

      randomCycles(1, 400);
      idle(1, 3, 1'b1);

      checkOutput("queue_empty", 0, 32'(qSize(0)), 32'h0);
      checkOutput("queue_empty", 1, 32'(qSize(1)), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
